// File: rtl/wca_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wca_reg_pkg
//  Description : Shared types and helpers for the shadow/active register bank:
//                byte-lane count, byte-lane merge and readback source select.
//  Revision    : 1.0  initial release
// ============================================================================
package wca_reg_pkg;

    // Which copy of a register the readback port returns.
    typedef enum logic {
        RD_ACTIVE = 1'b0,
        RD_SHADOW = 1'b1
    } rd_src_e;

    // Number of byte lanes in a register of the given width.
    function automatic int unsigned calc_nbe(input int unsigned width);
        return width / 8;
    endfunction

    // Merge one byte lane: take the new byte when its enable is set.
    function automatic logic [7:0] merge_be(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wca_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : wca_reg_slice
//  Description : One shadow+active register pair with dirty flag and
//                self-clearing pulse bits in the active copy.
//  Revision    : 1.0  initial release
// ============================================================================
module wca_reg_slice
    import wca_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter logic [WIDTH-1:0] PULSE_MASK  = '0,
    parameter bit               AUTO_COMMIT = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 wr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic [WIDTH/8-1:0]   wr_be_i,
    input  logic                 commit_i,
    output logic [WIDTH-1:0]     shadow_o,
    output logic [WIDTH-1:0]     active_o,
    output logic                 dirty_o
);

    localparam int unsigned NBE = calc_nbe(WIDTH);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             dirty_q,  dirty_d;
    logic [WIDTH-1:0] w_merged;

    // Byte-enable merge of incoming write data over the current shadow value.
    always_comb begin
        w_merged = shadow_q;
        for (int b = 0; b < NBE; b++) begin
            w_merged[8*b +: 8] = merge_be(shadow_q[8*b +: 8], wr_data_i[8*b +: 8], wr_be_i[b]);
        end
    end

    // Next state: pulse bits drop unless reloaded; commit copies the pre-write shadow.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q & ~PULSE_MASK;
        dirty_d  = dirty_q;
        if (AUTO_COMMIT) begin
            if (wr_i) begin
                shadow_d = w_merged;
                active_d = w_merged;
            end
            dirty_d = 1'b0;
        end else begin
            if (commit_i && dirty_q) begin
                active_d = shadow_q;
                dirty_d  = 1'b0;
            end
            if (wr_i) begin
                shadow_d = w_merged;
                dirty_d  = 1'b1;
            end
        end
    end

    // State registers; synchronous clear behaves exactly like reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
            dirty_q  <= 1'b0;
        end else if (clr_i) begin
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
            dirty_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;
    assign dirty_o  = dirty_q;

endmodule
`default_nettype wire

// File: rtl/wca_shadow_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : wca_shadow_reg_bank
//  Description : Bank of NREG shadow/active control registers with byte-enable
//                writes, atomic commit, pulse bits and registered readback.
//  Revision    : 1.0  initial release
// ============================================================================
module wca_shadow_reg_bank
    import wca_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NREG        = 8,
    parameter int unsigned      AW          = 3,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter logic [WIDTH-1:0] PULSE_MASK  = '0,
    parameter bit               AUTO_COMMIT = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic [WIDTH/8-1:0]      wr_be_i,
    input  logic                    commit_i,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    input  logic                    rd_shadow_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    rd_valid_o,
    output logic [NREG*WIDTH-1:0]   q_o,
    output logic [NREG-1:0]         dirty_o,
    output logic                    addr_err_o
);

    if (WIDTH % 8 != 0) begin : g_chk_width
        $error("WIDTH must be a multiple of 8");
    end
    if ((2 ** AW) < NREG) begin : g_chk_aw
        $error("AW too small to address NREG registers");
    end

    localparam logic [AW:0] c_NREG = (AW+1)'(NREG);

    logic             w_wr_ok;
    logic             w_wr_bad;
    logic             w_rd_bad;
    rd_src_e          w_rd_src;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_shadow [NREG];

    logic [WIDTH-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             addr_err_q, addr_err_d;

    assign w_wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < c_NREG);
    assign w_wr_bad = wr_en_i && ({1'b0, wr_addr_i} >= c_NREG);
    assign w_rd_bad = rd_en_i && ({1'b0, rd_addr_i} >= c_NREG);
    assign w_rd_src = rd_src_e'(rd_shadow_i);

    for (genvar k = 0; k < NREG; k++) begin : g_slice
        wca_reg_slice #(
            .WIDTH       (WIDTH),
            .RESET_VAL   (RESET_VAL),
            .PULSE_MASK  (PULSE_MASK),
            .AUTO_COMMIT (AUTO_COMMIT)
        ) u_slice (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clr_i     (clr_i),
            .wr_i      (w_wr_ok && (wr_addr_i == AW'(k))),
            .wr_data_i (wr_data_i),
            .wr_be_i   (wr_be_i),
            .commit_i  (commit_i),
            .shadow_o  (w_shadow[k]),
            .active_o  (q_o[k*WIDTH +: WIDTH]),
            .dirty_o   (dirty_o[k])
        );
    end

    // Read mux; out-of-range addresses fall through to zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NREG; k++) begin
            if (rd_addr_i == AW'(k)) begin
                w_rd_data = (w_rd_src == RD_SHADOW) ? w_shadow[k] : q_o[k*WIDTH +: WIDTH];
            end
        end
    end

    // Readback and error next state; read data holds while no read is requested.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en_i;
        addr_err_d = w_wr_bad || w_rd_bad;
        if (rd_en_i) begin
            rd_data_d = w_rd_data;
        end
    end

    // Readback and error registers; clear wins over any request in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (clr_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign addr_err_o = addr_err_q;

endmodule
`default_nettype wire
